// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and constants for the FP32 adder sharing logic.
package fpu_pkg;
  localparam int          FP_W    = 32;
  localparam int          EXP_W   = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int          REQ_N   = 2;

  typedef struct packed {
    logic ovf;
    logic udf;
  } fp_flags_t;

  function automatic logic [REQ_N-1:0] owner_onehot(input logic owner);
    logic [REQ_N-1:0] oh;
    oh        = '0;
    oh[owner] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester-side bundle: issue handshake, operands, responses and sticky flags.
interface fp_add_arbiter_if
  import fpu_pkg::*;
#(
  parameter int DATA_W = FP_W
);
  logic [REQ_N-1:0]  req_valid;
  logic [REQ_N-1:0]  req_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [REQ_N-1:0]  req_sub;
  logic [REQ_N-1:0]  rsp_valid;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_ovf;
  logic              rsp_udf;
  logic [REQ_N-1:0]  sticky_ovf;
  logic [REQ_N-1:0]  sticky_udf;
  logic [REQ_N-1:0]  flags_clr;

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, req_sub, flags_clr,
    input  req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_udf, sticky_ovf, sticky_udf
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, req_sub, flags_clr,
    output req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_udf, sticky_ovf, sticky_udf
  );
endinterface

// File: rtl/fp_add_arbiter_tag_pipe.sv
// Valid/owner shift register that tracks in-flight adder ops; flush empties it.
module fp_add_tag_pipe #(
  parameter int LAT   = 3,
  parameter int OWN_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [OWN_W-1:0] in_owner,
  output logic             out_valid,
  output logic [OWN_W-1:0] out_owner,
  output logic             any_valid
);
  logic [LAT-1:0]            vld_q, vld_d;
  logic [LAT-1:0][OWN_W-1:0] own_q, own_d;

  always_comb begin
    vld_d    = '0;
    own_d    = own_q;
    vld_d[0] = in_valid & ~flush;
    own_d[0] = in_owner;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1] & ~flush;
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  // Last stage lines up with the adder's result for the same op.
  assign out_valid = vld_q[LAT-1];
  assign out_owner = own_q[LAT-1];
  assign any_valid = |vld_q;
endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one fixed-latency FP32 adder between two requesters,
// with result steering back to the owner and per-requester sticky flags.
module fp_add_arbiter
  import fpu_pkg::*;
#(
  parameter int LAT    = 3,
  parameter int DATA_W = FP_W
) (
  input  logic              clk,
  input  logic              rst,
  fp_add_arbiter_if.slave   bus,
  input  logic              issue_en,
  input  logic              flush,
  output logic              add_valid,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_sub,
  input  logic [DATA_W-1:0] add_result,
  input  logic              add_ovf,
  input  logic              add_udf,
  output logic              busy
);
  logic [REQ_N-1:0]  eligible, grant;
  logic              winner;
  logic              prio_q, prio_d;
  logic              pipe_vld, pipe_any;
  logic [0:0]        pipe_own;
  logic              take;
  logic [REQ_N-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  fp_flags_t         rsp_flags_q, rsp_flags_d;
  logic [REQ_N-1:0]  sticky_ovf_q, sticky_ovf_d;
  logic [REQ_N-1:0]  sticky_udf_q, sticky_udf_d;

  // Arbitration: prio only matters when both requesters are eligible.
  always_comb begin
    eligible = bus.req_valid & {REQ_N{issue_en & ~flush}};
    grant    = eligible;
    if (&eligible) grant = prio_q ? 2'b10 : 2'b01;
    winner = grant[1];
    prio_d = (|grant) ? ~winner : prio_q;
  end

  assign bus.req_ready = grant;
  assign add_valid     = |grant;
  assign add_a         = winner ? bus.req1_a : bus.req0_a;
  assign add_b         = winner ? bus.req1_b : bus.req0_b;
  assign add_sub       = bus.req_sub[winner];

  fp_add_tag_pipe #(
    .LAT   (LAT),
    .OWN_W (1)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (add_valid),
    .in_owner  (winner),
    .out_valid (pipe_vld),
    .out_owner (pipe_own),
    .any_valid (pipe_any)
  );

  // A result arriving in the flush cycle is dropped along with the pipe contents.
  always_comb begin
    take         = pipe_vld & ~flush;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    if (take) begin
      rsp_valid_d     = owner_onehot(pipe_own[0]);
      rsp_result_d    = add_result;
      rsp_flags_d.ovf = add_ovf;
      rsp_flags_d.udf = add_udf;
    end
  end

  // Sticky set beats a same-cycle clear so no event is lost.
  always_comb begin
    sticky_ovf_d = sticky_ovf_q;
    sticky_udf_d = sticky_udf_q;
    for (int i = 0; i < REQ_N; i++) begin
      sticky_ovf_d[i] = (sticky_ovf_q[i] & ~bus.flags_clr[i]) | (rsp_valid_q[i] & rsp_flags_q.ovf);
      sticky_udf_d[i] = (sticky_udf_q[i] & ~bus.flags_clr[i]) | (rsp_valid_q[i] & rsp_flags_q.udf);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q       <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      sticky_ovf_q <= '0;
      sticky_udf_q <= '0;
    end else begin
      prio_q       <= prio_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_udf_q <= sticky_udf_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_ovf    = rsp_flags_q.ovf;
  assign bus.rsp_udf    = rsp_flags_q.udf;
  assign bus.sticky_ovf = sticky_ovf_q;
  assign bus.sticky_udf = sticky_udf_q;
  assign busy           = pipe_any | (|rsp_valid_q);
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a table-driven stand-in for the FP adder.
module tb_fp_add_arbiter;
  import fpu_pkg::*;

  localparam int LAT = 3;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_en;
  logic          flush;
  logic          add_valid;
  logic [DW-1:0] add_a, add_b, add_result;
  logic          add_sub, add_ovf, add_udf;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_arbiter_if #(.DATA_W(DW)) bus ();

  fp_add_arbiter #(.LAT(LAT), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .issue_en   (issue_en),
    .flush      (flush),
    .add_valid  (add_valid),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sub    (add_sub),
    .add_result (add_result),
    .add_ovf    (add_ovf),
    .add_udf    (add_udf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Known sums for the vectors used here: {ovf, udf, result}.
  function automatic logic [33:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic sub);
    if (!sub && a == 32'h3F800000 && b == 32'h3F800000) return {2'b00, 32'h40000000};
    if (!sub && a == 32'h3F800000 && b == 32'h40000000) return {2'b00, 32'h40400000};
    if (!sub && a == 32'h40000000 && b == 32'h40000000) return {2'b00, 32'h40800000};
    if (!sub && a == 32'h40400000 && b == 32'h3F800000) return {2'b00, 32'h40800000};
    if (!sub && a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {2'b10, 32'h7F800000};
    if (sub  && a == 32'h00800001 && b == 32'h00800000) return {2'b01, 32'h00000001};
    return {2'b00, 32'hDEADBEEF};
  endfunction

  // Adder stand-in computes every cycle, so results appear whether or not an op was issued.
  logic [33:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= fadd(add_a, add_b, add_sub);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign {add_ovf, add_udf, add_result} = mp[LAT-1];

  task automatic idle();
    bus.req_valid = 2'b00;
    bus.flags_clr = 2'b00;
    bus.req_sub   = 2'b00;
    flush         = 1'b0;
    issue_en      = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    #2;
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
    n_checks++; if (bus.rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result got=%h exp=0", bus.rsp_result); end
    n_checks++; if ({bus.sticky_ovf, bus.sticky_udf} !== 4'b0) begin n_fail++; $display("FAIL reset_sticky got=%b%b exp=0000", bus.sticky_ovf, bus.sticky_udf); end
    n_checks++; if ({busy, add_valid, bus.req_ready} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b%b%b exp=0000", busy, add_valid, bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int          lat;
    logic [31:0] got;
    do_reset();
    lat = -1;
    got = '0;
    bus.req_valid = 2'b01;
    bus.req0_a    = 32'h3F800000;
    bus.req0_b    = 32'h40000000;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01 || add_valid !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b/%b exp=01/1", bus.req_ready, add_valid); end
    n_checks++; if (add_a !== 32'h3F800000 || add_b !== 32'h40000000) begin n_fail++; $display("FAIL single_mux got=%h %h exp=3f800000 40000000", add_a, add_b); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    for (int k = 1; k <= LAT + 3; k++) begin
      if (bus.rsp_valid[1]) begin n_checks++; n_fail++; $display("FAIL single_wrong_owner got=%b exp=01", bus.rsp_valid); end
      if (bus.rsp_valid[0] && lat < 0) begin lat = k; got = bus.rsp_result; end
      @(posedge clk); #1;
    end
    n_checks++; if (lat != LAT + 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT + 1); end
    n_checks++; if (got !== 32'h40400000) begin n_fail++; $display("FAIL single_result got=%h exp=40400000", got); end
    n_checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_result !== 32'h40400000) begin n_fail++; $display("FAIL single_hold got=%b %h exp=00 40400000", bus.rsp_valid, bus.rsp_result); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_res [4] = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h40800000};
    int          idx;
    do_reset();
    for (int c = 0; c < 4 + LAT + 2; c++) begin
      bus.req_valid = (c < 4) ? 2'b11 : 2'b00;
      bus.req0_a = 32'h3F800000;
      bus.req0_b = (c == 0) ? 32'h3F800000 : 32'h40000000;
      bus.req1_a = (c <= 1) ? 32'h40000000 : 32'h40400000;
      bus.req1_b = (c <= 1) ? 32'h40000000 : 32'h3F800000;
      #1;
      if (c < 4) begin
        n_checks++; if (bus.req_ready !== exp_gnt[c]) begin n_fail++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, exp_gnt[c]); end
      end
      @(posedge clk); #1;
      idx = c - LAT;
      if (idx >= 0 && idx < 4) begin
        n_checks++; if (bus.rsp_valid !== exp_gnt[idx] || bus.rsp_result !== exp_res[idx]) begin
          n_fail++; $display("FAIL rr_rsp idx=%0d got=%b %h exp=%b %h", idx, bus.rsp_valid, bus.rsp_result, exp_gnt[idx], exp_res[idx]);
        end
      end else begin
        n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rr_idle c=%0d got=%b exp=00", c, bus.rsp_valid); end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.req1_a = 32'h7F7FFFFF;
    bus.req1_b = 32'h7F7FFFFF;
    for (int c = 0; c <= LAT + 1; c++) begin
      bus.req_valid = (c == 0) ? 2'b10 : 2'b00;
      @(posedge clk); #1;
      if (c == LAT) begin
        n_checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'h7F800000 || bus.rsp_ovf !== 1'b1) begin
          n_fail++; $display("FAIL ovf_rsp got=%b %h %b exp=10 7f800000 1", bus.rsp_valid, bus.rsp_result, bus.rsp_ovf);
        end
      end
    end
    n_checks++; if (bus.sticky_ovf !== 2'b10 || bus.sticky_udf !== 2'b00) begin n_fail++; $display("FAIL ovf_sticky got=%b/%b exp=10/00", bus.sticky_ovf, bus.sticky_udf); end
    bus.flags_clr = 2'b10;
    @(posedge clk); #1;
    bus.flags_clr = 2'b00;
    n_checks++; if (bus.sticky_ovf !== 2'b00) begin n_fail++; $display("FAIL ovf_clear got=%b exp=00", bus.sticky_ovf); end
  endtask

  task automatic test_clr_collision();
    do_reset();
    bus.req0_a  = 32'h00800001;
    bus.req0_b  = 32'h00800000;
    bus.req_sub = 2'b01;
    for (int c = 0; c <= LAT + 2; c++) begin
      bus.req_valid = (c == 0) ? 2'b01 : 2'b00;
      bus.flags_clr = (c >= LAT + 1) ? 2'b01 : 2'b00;
      #1;
      if (c == 0) begin
        n_checks++; if (add_sub !== 1'b1) begin n_fail++; $display("FAIL clr_sub got=%b exp=1", add_sub); end
      end
      if (c == LAT + 1) begin
        n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_udf !== 1'b1 || bus.sticky_udf !== 2'b00) begin
          n_fail++; $display("FAIL clr_pre got=%b %b %b exp=01 1 00", bus.rsp_valid, bus.rsp_udf, bus.sticky_udf);
        end
      end
      @(posedge clk); #1;
      if (c == LAT + 1) begin
        n_checks++; if (bus.sticky_udf !== 2'b01) begin n_fail++; $display("FAIL clr_set_wins got=%b exp=01", bus.sticky_udf); end
      end
      if (c == LAT + 2) begin
        n_checks++; if (bus.sticky_udf !== 2'b00) begin n_fail++; $display("FAIL clr_after got=%b exp=00", bus.sticky_udf); end
      end
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    bus.req0_a = 32'h3F800000;
    bus.req0_b = 32'h3F800000;
    for (int c = 0; c <= LAT + 3; c++) begin
      bus.req_valid = (c <= 3) ? 2'b01 : 2'b00;
      flush         = (c == 3);
      #1;
      if (c < 3) begin
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL flush_issue c=%0d got=%b exp=01", c, bus.req_ready); end
      end
      if (c == 3) begin
        n_checks++; if (bus.req_ready !== 2'b00 || add_valid !== 1'b0) begin n_fail++; $display("FAIL flush_block got=%b/%b exp=00/0", bus.req_ready, add_valid); end
      end
      @(posedge clk); #1;
      if (c >= 3) begin
        n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL flush_rsp c=%0d got=%b exp=00", c, bus.rsp_valid); end
      end
      if (c == 3) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
      end
    end
    idle();
  endtask

  task automatic test_throttle();
    do_reset();
    issue_en      = 1'b0;
    bus.req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (bus.req_ready !== 2'b00 || add_valid !== 1'b0) begin n_fail++; $display("FAIL throttle c=%0d got=%b/%b exp=00/0", c, bus.req_ready, add_valid); end
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL throttle_busy c=%0d got=%b exp=0", c, busy); end
    end
    issue_en = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL throttle_release got=%b exp=01", bus.req_ready); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.req0_a = 32'h3F800000; bus.req0_b = 32'h3F800000;
    bus.req1_a = 32'h40000000; bus.req1_b = 32'h40000000;
    bus.req_valid = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_pre got=%b exp=1", busy); end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    for (int c = 0; c < LAT + 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_stray c=%0d got=%b/%b exp=00/0", c, bus.rsp_valid, busy); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_a = '0; bus.req1_b = '0;
    idle();
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_clr_collision();
    test_flush();
    test_throttle();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
